fifo_rd_fwft: RTL and testbench

- Read-side output stage of the async FIFO. Sits downstream of the read-pointer/empty logic and the dual-port RAM read port.
- Converts the FIFO's rempty/rinc/registered-rdata interface into a first-word-fall-through valid/ready stream for the rclk-domain consumer.
- Hides the 1-cycle RAM read latency with a 3-entry prefetch buffer. Sustains one word per rclk with no combinational path from m_ready to rinc.

---
 rtl/fifo_rd_fwft_pkg.sv | 20 ++
 rtl/fifo_rd_fwft_if.sv | 24 ++
 rtl/fifo_rd_fwft_store.sv | 43 ++++
 rtl/fifo_rd_fwft.sv | 98 +++++++++
 tb/tb_fifo_rd_fwft.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_fwft_pkg.sv
// Shared definitions for the read-side FWFT output stage of the async FIFO.
//   DSIZE_DEF  : default data word width
//   FWFT_DEPTH : prefetch buffer entries. Three is the smallest depth that
//                keeps one word per rclk while the credit check counts both
//                held words and the word still in the RAM read pipeline.
//   CNT_W      : width of the buffer pointers and the occupancy count
//   ptr_inc()  : modulo-FWFT_DEPTH pointer increment (2 -> 0)
package fifo_rd_fwft_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int FWFT_DEPTH = 3;
  localparam int CNT_W      = 2;

  typedef logic [CNT_W-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FWFT_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// Consumer-side stream of the FWFT output stage.
//   m_valid : a word is presented on m_data
//   m_ready : consumer can take the word
//   m_data  : stream data word
//   m_count : words currently held in the prefetch buffer (0..3)
//
// Handshake: a word moves on a rising rclk when m_valid && m_ready are both
// high. m_valid never depends on m_ready; once raised it stays high, with
// m_data held stable, until that transfer happens.
interface fifo_rd_fwft_if
  import fifo_rd_fwft_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);

  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic [CNT_W-1:0] m_count;

  modport master (output m_valid, output m_data, output m_count, input m_ready);
  modport slave  (input m_valid, input m_data, input m_count, output m_ready);

endinterface

// File: rtl/fifo_rd_fwft_store.sv
// Three-entry word store for the prefetch buffer: one write port, one read
// mux. The entries are plain data flops without reset; the parent only
// presents them while its occupancy says they hold a real word.
//   rclk  : read-domain clock
//   we    : write enable (a RAM word is landing)
//   waddr : entry to write
//   wdata : word to write
//   raddr : entry driven onto q
//   q     : selected entry, straight from the flops
module fifo_rd_fwft_store
  import fifo_rd_fwft_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             we,
  input  ptr_t             waddr,
  input  logic [DSIZE-1:0] wdata,
  input  ptr_t             raddr,
  output logic [DSIZE-1:0] q
);

  logic [DSIZE-1:0] mem [FWFT_DEPTH];

  always_ff @(posedge rclk) begin
    for (int i = 0; i < FWFT_DEPTH; i++) begin
      if (we && (waddr == ptr_t'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  // Pointer value 3 never occurs; it falls back to entry 0.
  always_comb begin
    q = mem[0];
    case (raddr)
      2'd1:    q = mem[1];
      2'd2:    q = mem[2];
      default: q = mem[0];
    endcase
  end

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-side output stage of the async FIFO. Turns the rempty / rinc /
// registered-rdata interface of the read-pointer stage and RAM into a
// first-word-fall-through valid/ready stream, hiding the one-cycle RAM read
// latency behind a three-entry prefetch buffer.
//   rclk   : read-domain clock
//   rrst_n : asynchronous active-low reset, shared with the read pointer
//   rempty : registered FIFO empty flag
//   rinc   : read-increment request to the read-pointer stage
//   rdata  : RAM read data, valid in the cycle after rinc
//   m      : consumer stream (m_valid, m_ready, m_data, m_count)
//
// rinc depends only on rempty and local state, never on m_ready, so there
// is no combinational path from the consumer back into the FIFO.
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [DSIZE-1:0]      rdata,
  fifo_rd_fwft_if.master        m
);

  localparam logic [CNT_W:0] DEPTH_C = FWFT_DEPTH[CNT_W:0];

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             inflight;  // rinc of the previous cycle: rdata is live now
  logic             valid_q;

  logic [CNT_W:0]   committed;
  logic             credit;
  logic             pop;
  logic [CNT_W-1:0] occ_next;

  // Words held plus the word on its way from the RAM. Requesting only while
  // this is below the depth means a landing always finds a free entry.
  assign committed = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
  assign credit    = (committed < DEPTH_C);

  // Gated by rrst_n so the request drops the moment reset asserts, even if
  // the empty flag has not yet caught up with the pointer reset.
  assign rinc = rrst_n & ~rempty & credit;

  assign pop      = valid_q & m.m_ready;
  assign occ_next = occ + CNT_W'(inflight) - CNT_W'(pop);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      inflight <= rinc;
      if (inflight) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occ     <= occ_next;
      valid_q <= (occ_next != '0);
    end
  end

  fifo_rd_fwft_store #(
    .DSIZE (DSIZE)
  ) u_store (
    .rclk  (rclk),
    .we    (inflight),
    .waddr (wr_ptr),
    .wdata (rdata),
    .raddr (rd_ptr),
    .q     (m.m_data)
  );

  assign m.m_valid = valid_q;
  assign m.m_count = occ;

  a_no_land_when_full : assert property (
    @(posedge rclk) disable iff (!rrst_n) !(inflight && (occ == CNT_W'(FWFT_DEPTH))))
    else $error("landing into a full prefetch buffer");

  a_committed_bound : assert property (
    @(posedge rclk) disable iff (!rrst_n) committed <= DEPTH_C)
    else $error("held plus in-flight words exceed buffer depth");

  a_no_rinc_when_empty : assert property (
    @(posedge rclk) disable iff (!rrst_n) !(rinc && rempty))
    else $error("read increment issued while empty");

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Directed plus short random bench for fifo_rd_fwft. The bench plays the
// read-pointer stage and RAM: a source queue holds the words still in the
// FIFO, rempty follows that queue (optionally forced high), and each rinc
// pops a source word, presents it on rdata in the following cycle and pushes
// it to the expected queue. Every accepted stream word is compared against
// the head of the expected queue.
module tb_fifo_rd_fwft;
  import fifo_rd_fwft_pkg::*;

  localparam int W = 8;

  logic         rclk = 1'b0;
  logic         rrst_n;
  logic         rempty;
  logic         rinc;
  logic [W-1:0] rdata;

  fifo_rd_fwft_if #(.DSIZE(W)) m_if ();

  fifo_rd_fwft #(.DSIZE(W)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rinc   (rinc),
    .rdata  (rdata),
    .m      (m_if.master)
  );

  // ---------------- clock ----------------
  always #5 rclk = ~rclk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic         pend;
  logic [W-1:0] pend_word;
  logic         hold_empty;
  int           n_checks;
  int           n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled at the falling edge: decides what the next rising edge does.
  task automatic sample();
    if (!rrst_n) begin
      pend = 1'b0;
      return;
    end
    if (m_if.m_valid && m_if.m_ready) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("sb_data", 32'(m_if.m_data), 32'(exp_q.pop_front()));
      end
    end
    pend = 1'b0;
    if (rinc) begin
      check("rinc_vs_rempty", 32'(rempty), 32'd0);
      if (src_q.size() != 0) begin
        pend_word = src_q.pop_front();
        pend      = 1'b1;
        exp_q.push_back(pend_word);
      end
    end
  endtask

  // One rclk: sample, cross the edge, drive RAM data and the empty flag.
  task automatic cyc();
    @(negedge rclk);
    sample();
    @(posedge rclk);
    #1;
    rdata  = pend ? pend_word : W'($urandom_range(0, 255));
    rempty = hold_empty | (src_q.size() == 0);
    #1;
  endtask

  task automatic load(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + W'(i));
    rempty = hold_empty | (src_q.size() == 0);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n          = 0;
    m_if.m_ready = 1'b1;
    hold_empty = 1'b0;
    rempty     = (src_q.size() == 0);
    #1;
    while (!(src_q.size() == 0 && exp_q.size() == 0 && !m_if.m_valid && !rinc) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
    check({tag, "_drain_count"}, 32'(m_if.m_count), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    pend         = 1'b0;
    pend_word    = '0;
    hold_empty   = 1'b0;
    rdata        = '0;
    rrst_n       = 1'b0;
    m_if.m_ready = 1'b1;
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    rempty       = 1'b0;
    #2;

    // 1: reset holds everything idle even with rempty=0 and m_ready=1
    for (int i = 0; i < 3; i++) begin
      check("rst_rinc", 32'(rinc), 32'd0);
      check("rst_valid", 32'(m_if.m_valid), 32'd0);
      check("rst_count", 32'(m_if.m_count), 32'd0);
      cyc();
    end
    rrst_n = 1'b1;
    #1;
    check("rel_first_rinc", 32'(rinc), 32'd1);
    drain("t1", 20);

    // 2: single word, held under backpressure, cleared after acceptance
    m_if.m_ready = 1'b0;
    load(8'hA5, 1);
    check("t2_c0_rinc", 32'(rinc), 32'd1);
    cyc();
    check("t2_c1_rinc", 32'(rinc), 32'd0);
    check("t2_c1_valid", 32'(m_if.m_valid), 32'd0);
    cyc();
    check("t2_c2_valid", 32'(m_if.m_valid), 32'd1);
    check("t2_c2_data", 32'(m_if.m_data), 32'h0A5);
    check("t2_c2_count", 32'(m_if.m_count), 32'd1);
    cyc();
    check("t2_c3_valid", 32'(m_if.m_valid), 32'd1);
    check("t2_c3_data", 32'(m_if.m_data), 32'h0A5);
    m_if.m_ready = 1'b1;
    cyc();
    check("t2_c4_valid", 32'(m_if.m_valid), 32'd0);
    check("t2_c4_count", 32'(m_if.m_count), 32'd0);
    check("t2_exp_empty", 32'(exp_q.size()), 32'd0);

    // 3: streaming at one word per cycle
    m_if.m_ready = 1'b1;
    load(8'h01, 10);
    check("t3_c0_rinc", 32'(rinc), 32'd1);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      check("t3_rinc", 32'(rinc), 32'd1);
      if (c >= 2) begin
        check("t3_valid", 32'(m_if.m_valid), 32'd1);
        check("t3_count", 32'(m_if.m_count), 32'd1);
      end
    end
    drain("t3", 20);

    // 4: backpressure fills exactly three entries, then refills seamlessly
    m_if.m_ready = 1'b0;
    load(8'h01, 8);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc();
      check("t4_rinc", 32'(rinc), (c <= 2) ? 32'd1 : 32'd0);
      case (c)
        2:       check("t4_count", 32'(m_if.m_count), 32'd1);
        3:       check("t4_count", 32'(m_if.m_count), 32'd2);
        4, 5:    check("t4_count", 32'(m_if.m_count), 32'd3);
        default: check("t4_count", 32'(m_if.m_count), 32'd0);
      endcase
    end
    m_if.m_ready = 1'b1;
    for (int c = 6; c <= 10; c++) begin
      cyc();
      check("t4_valid", 32'(m_if.m_valid), 32'd1);
    end
    drain("t4", 20);

    // 5: rempty rises while a word is in flight
    m_if.m_ready = 1'b1;
    load(8'h3C, 1);
    check("t5_c0_rinc", 32'(rinc), 32'd1);
    cyc();
    check("t5_c1_rinc", 32'(rinc), 32'd0);
    cyc();
    check("t5_c2_valid", 32'(m_if.m_valid), 32'd1);
    check("t5_c2_data", 32'(m_if.m_data), 32'h03C);
    check("t5_c2_rinc", 32'(rinc), 32'd0);
    cyc();
    check("t5_c3_valid", 32'(m_if.m_valid), 32'd0);
    check("t5_c3_rinc", 32'(rinc), 32'd0);
    check("t5_exp_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset with two words held and one in flight
    m_if.m_ready = 1'b0;
    load(8'h51, 5);
    for (int c = 1; c <= 3; c++) cyc();
    check("t6_count_pre", 32'(m_if.m_count), 32'd2);
    check("t6_rinc_pre", 32'(rinc), 32'd0);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_if.m_valid), 32'd0);
    check("t6_rst_count", 32'(m_if.m_count), 32'd0);
    check("t6_rst_rinc", 32'(rinc), 32'd0);
    exp_q.delete();
    src_q.delete();
    pend = 1'b0;
    cyc();
    cyc();
    m_if.m_ready = 1'b1;
    load(8'h61, 4);
    rrst_n = 1'b1;
    #1;
    check("t6_rel_rinc", 32'(rinc), 32'd1);
    cyc();
    check("t6_c1_valid", 32'(m_if.m_valid), 32'd0);
    cyc();
    check("t6_c2_valid", 32'(m_if.m_valid), 32'd1);
    check("t6_c2_data", 32'(m_if.m_data), 32'h061);
    drain("t6", 20);

    // random ready and empty-flag gaps over a longer stream
    load(8'h80, 40);
    for (int c = 0; c < 400 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      m_if.m_ready = ($urandom_range(0, 3) != 0);
      hold_empty   = ($urandom_range(0, 4) == 0);
      cyc();
      check("rnd_count_le_3", 32'(m_if.m_count <= 2'd3), 32'd1);
    end
    drain("rnd", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
